// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture,
// stop-bit check with break handling, and a one-entry valid/ready output stage.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_x16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t       state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 deliver;
    logic                 stop_bad;
    logic                 rx_s;
    logic                 armed;
    logic [1:0]           settle;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        deliver     = 1'b0;
        stop_bad    = 1'b0;
        if (tick_x16) begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt_nxt = '0;
                        if (!rx_s) begin
                            state_nxt   = DATA;
                            bit_idx_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt     = '0;
                        shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (rx_s) begin
                            deliver   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_nxt = BREAK_WAIT;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // A line held low through reset must not look like a start bit: arm only
    // after the synchronizer has flushed its reset value and seen a real high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (tick_x16 && settle[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shreg;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 50 MHz-style clock with a tick every 27 clk, 16 ticks per bit.
module tb_uart_rx;

    localparam int TICK_DIV = 27;
    localparam int OS       = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_x16 = 1'b0;
    logic       rxd;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int div = 0;

    logic       valid_prev = 1'b0;
    int         fall_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         busy_cnt = 0;
    logic [7:0] rx_q[$];

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_x16  (tick_x16),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_x16 = (div == TICK_DIV - 1);
        div = (div == TICK_DIV - 1) ? 0 : div + 1;
    end

    always @(posedge clk) begin
        #1;
        if (out_valid && !valid_prev) rx_q.push_back(out_data);
        if (!out_valid && valid_prev) fall_cnt++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (busy) busy_cnt++;
        valid_prev = out_valid;
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff tick_x16);
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_ticks(OS);
    endtask

    // Bits are aligned to ticks; with ready_at_stop the consumer accepts in
    // exactly the clk of the stop-bit sample (tick 153 after the start edge).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit ready_at_stop);
        @(posedge clk iff tick_x16);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (!ready_at_stop) begin
            drive_bit(stop_bit);
        end else begin
            rxd = stop_bit;
            repeat (8) @(posedge clk iff tick_x16);
            repeat (TICK_DIV - 1) @(posedge clk);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            wait_ticks(7);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        wait_ticks(2 * OS);
    endtask

    task automatic test_back_to_back;
        int q0, f0, o0;
        q0 = rx_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        out_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        wait_ticks(OS);
        n_cmp++; if (rx_q.size() - q0 !== 2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size() - q0); end
        if (rx_q.size() - q0 >= 2) begin
            n_cmp++; if (rx_q[q0] !== 8'h55) begin n_err++; $display("FAIL b2b_first: got %h expected 55", rx_q[q0]); end
            n_cmp++; if (rx_q[q0+1] !== 8'hA3) begin n_err++; $display("FAIL b2b_second: got %h expected a3", rx_q[q0+1]); end
        end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); end
        n_cmp++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL b2b_ovr: got %0d expected 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch;
        int q0, f0, b0;
        q0 = rx_q.size(); f0 = ferr_cnt; b0 = busy_cnt;
        @(posedge clk iff tick_x16);
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(posedge clk iff tick_x16);
        @(negedge clk);
        rxd = 1'b1;
        wait_ticks(2 * OS);
        n_cmp++; if ((busy_cnt - b0 > 0) !== 1'b1) begin n_err++; $display("FAIL glitch_start_seen: got %0d busy clks expected >0", busy_cnt - b0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b expected 0", busy); end
        n_cmp++; if (rx_q.size() - q0 !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d expected 0", rx_q.size() - q0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_error;
        int q0, f0;
        q0 = rx_q.size(); f0 = ferr_cnt;
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(2 * OS);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
        n_cmp++; if (rx_q.size() - q0 !== 0) begin n_err++; $display("FAIL ferr_no_valid: got %0d expected 0", rx_q.size() - q0); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
        rxd = 1'b1;
        wait_ticks(OS);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_release: got %b expected 0", busy); end
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(OS);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_err++; $display("FAIL ferr_next_count: got %0d expected 1", rx_q.size() - q0); end
        if (rx_q.size() - q0 >= 1) begin
            n_cmp++; if (rx_q[q0] !== 8'h81) begin n_err++; $display("FAIL ferr_next_data: got %h expected 81", rx_q[q0]); end
        end
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_total: got %0d expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_overrun;
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_ticks(4);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL ovr_data_kept: got %h expected 11", out_data); end
        n_cmp++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulse: got %0d expected 1", ovr_cnt - o0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL ovr_ferr: got %0d expected 0", ferr_cnt - f0); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_accept_clear: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_accept_same_clk;
        int o0, v0;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        wait_ticks(2);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL same_pre_valid: got %b expected 1", out_valid); end
        o0 = ovr_cnt; v0 = fall_cnt;
        send_frame(8'h22, 1'b1, 1'b1);
        wait_ticks(4);
        n_cmp++; if (out_data !== 8'h22) begin n_err++; $display("FAIL same_data: got %h expected 22", out_data); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL same_valid: got %b expected 1", out_valid); end
        n_cmp++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL same_ovr: got %0d expected 0", ovr_cnt - o0); end
        n_cmp++; if (fall_cnt - v0 !== 0) begin n_err++; $display("FAIL same_valid_gap: got %0d drops expected 0", fall_cnt - v0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int q0;
        d = 8'hA5;
        @(posedge clk iff tick_x16);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rxd = d[4];
        repeat (8) @(posedge clk iff tick_x16);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %h expected 00", out_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_ferr: got %b expected 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovr: got %b expected 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        q0 = rx_q.size();
        wait_ticks(2 * OS);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_low_no_start: got %b expected 0", busy); end
        rxd = 1'b1;
        out_ready = 1'b1;
        wait_ticks(OS);
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_ticks(OS);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_err++; $display("FAIL mid_next_count: got %0d expected 1", rx_q.size() - q0); end
        if (rx_q.size() - q0 >= 1) begin
            n_cmp++; if (rx_q[q0] !== 8'h7E) begin n_err++; $display("FAIL mid_next_data: got %h expected 7e", rx_q[q0]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_accept_same_clk();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit period (even, >=8).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick_x16  input  1  one-clk enable pulse at BAUD*OVERSAMPLE from the baud generator.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port out_data  output  DATA_BITS  received byte, valid while out_valid=1.
REQ-008 SHALL have port out_valid  output  1  byte available; held until accepted.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid&&out_ready.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse when the stop bit samples 0.
REQ-011 SHALL have port overrun  output  1  one-clk pulse when a completed byte is dropped.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (rx_s), 2-clk latency; both flops reset to 1.
REQ-014 SHALL advance the FSM and sample counter only on clocks with tick_x16=1; with no tick, all state holds.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-016 IDLE: on a tick with rx_s=0 -> START with cnt=0.
REQ-017 START: cnt increments per tick; on the tick where cnt=OVERSAMPLE/2-1 (mid start bit), if rx_s=0 -> DATA with cnt=0 and bit_idx=0, else -> IDLE (glitch reject, no outputs).
REQ-018 DATA: on the tick where cnt=OVERSAMPLE-1, SHALL sample rx_s into the shift register LSB-first, reset cnt to 0, and increment bit_idx; after sample DATA_BITS -> STOP.
REQ-019 STOP: on the tick where cnt=OVERSAMPLE-1, if rx_s=1, SHALL deliver the byte (REQ-021) and go -> IDLE; if rx_s=0, SHALL pulse frame_err, discard the byte, and go -> BREAK_WAIT.
REQ-020 BREAK_WAIT: on a tick with rx_s=1 -> IDLE; no new frame starts while the line is held low.
REQ-021 Delivery: if out_valid=0, or out_valid=1 with out_ready=1 in the same clk, SHALL load out_data and set out_valid=1 on the next edge with no overrun; if out_valid=1 and out_ready=0, SHALL pulse overrun, keep old out_data, and drop the new byte.
REQ-022 out_valid SHALL clear on the edge after out_valid&&out_ready unless a delivery occurs in that same clk.
REQ-023 Latency: out_valid SHALL rise 1 clk after the stop-bit sampling tick.
REQ-024 cnt width SHALL be $clog2(OVERSAMPLE) bits and bit_idx width $clog2(DATA_BITS+1) bits; cnt wraps only via explicit reset to 0.
REQ-025 frame_err and overrun SHALL never assert in the same clk.

Reset
REQ-026 Asserting rst at any time, including mid-frame, SHALL force IDLE, cnt=0, bit_idx=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0, and synchronizer flops=1.
REQ-027 After rst deasserts, the first frame SHALL be detected only on a new high-to-low rxd edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enum uart_rx_state_t and default constants UART_OVERSAMPLE=16 and UART_DATA_BITS=8.
REQ-029 The synchronizer SHALL be a sub-module named uart_sync2 (parameterized reset value); all other logic lives in uart_rx.

Verification
REQ-030 At 50 MHz with 115200 baud (tick every 27 clk), send 0x55 then 0xA3 with out_ready=1 -> out_data=0x55 then 0xA3, one out_valid each, no error pulses.
REQ-031 Drive a 3-tick low glitch on idle rxd -> FSM returns to IDLE, no out_valid, no frame_err.
REQ-032 Send 0x3C with a stop bit of 0 and hold rxd low for 2 bit times -> one frame_err pulse, no out_valid, busy stays 1 until rxd returns high, then the next 0x81 frame is received correctly.
REQ-033 With out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, one overrun pulse at the 0x22 stop sample; raising out_ready then clears out_valid.
REQ-034 With out_valid=1, assert out_ready in the same clk as the 0x22 delivery -> out_data=0x22, out_valid stays 1, no overrun.
REQ-035 Assert rst during DATA bit 4 of a frame -> all outputs reset per REQ-026, and a following 0x7E frame is received correctly.
